onehot_issue_decoder: RTL and testbench
=======================================

Name: onehot_issue_decoder

Overview:
- Decodes a binary index into a one-hot select vector: the inverse direction of the one-hot-to-binary encoder used across the codebase.
- Adds a valid/ready input handshake, a registered one-hot output, and a one-entry pending buffer.
- The one-hot output is held until the selected target returns its per-entry acknowledge.
- Used to issue requests or grants to one of NUM_ENTRY lanes, for example a selected port or buffer slot.

Parameters:
- NUM_ENTRY, 8, number of one-hot lanes (>=2, need not be a power of 2).
- TIMEOUT, 16, cycles to wait for an acknowledge before dropping the issue; used only when DECODER_TIMEOUT_EN is defined.
- Derived: WIDTH_IDX = $clog2(NUM_ENTRY).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- I_Valid  input  1  index request valid.
- I_Index  input  WIDTH_IDX  binary index to decode.
- O_Ready  output  1  block can accept a request this cycle.
- O_Valid  output  1  O_OneHot holds a live issue.
- O_OneHot  output  NUM_ENTRY  registered one-hot select; all-zero when O_Valid=0.
- I_Ack  input  NUM_ENTRY  per-lane acknowledge from targets.
- O_Err  output  1  one-cycle pulse: accepted index was >= NUM_ENTRY.
- O_Timeout  output  1  one-cycle pulse on timeout drop; tied 0 without DECODER_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high) clears all state: O_Valid=0, O_OneHot='0, O_Err=0, O_Timeout=0, pending buffer empty, O_Ready=1. Reset mid-issue discards both the current and the pending entry, with no pulses.
- Accept: a request is accepted when I_Valid & O_Ready at the clock edge. O_Ready = !pend_valid, which is a registered, combinationally stable term.
- Range check: an accepted index >= NUM_ENTRY is consumed. It raises O_Err=1 in the next cycle, is never placed in cur or pend, and leaves state unchanged otherwise.
- State machine states:
  - EMPTY: cur invalid.
  - ONE: cur valid, pend empty.
  - TWO: cur and pend both valid.
- Ack definition: ack = |(I_Ack & O_OneHot). Ack bits on non-selected lanes are ignored. An ack while O_Valid=0 is ignored.
- EMPTY + accept(valid index) -> ONE. O_OneHot = 1<<I_Index from the next cycle, so latency is 1 cycle.
- ONE + ack + no accept -> EMPTY next cycle.
- ONE + ack + accept -> ONE with the new index next cycle. This is a bypass into cur with no bubble.
- ONE + no ack + accept -> TWO; the index is stored in pend.
- ONE + no ack + no accept -> hold.
- TWO + ack -> ONE. pend moves to cur next cycle. O_Ready=0 throughout TWO, so no accept can occur.
- TWO + no ack -> hold.
- O_OneHot always has exactly one bit set while O_Valid=1, and is '0 otherwise.
- Order is strictly FIFO: pend is never issued before cur is acknowledged.
- Throughput: one issue per cycle when targets ack in the same cycle the one-hot is presented.

Optional Feature:
- Macro: DECODER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit wait counter resets to 0 whenever a new entry is loaded into cur, and increments each cycle cur is valid without an ack.
  - When the counter reaches TIMEOUT-1 with no ack in that cycle, cur is dropped exactly as if acked (pend is promoted, or the state goes to EMPTY). O_Timeout pulses 1 cycle later.
  - An ack in the same cycle as the timeout wins; no O_Timeout pulse is raised.
- Not defined: no counter exists, O_Timeout is constant 0, and an issue waits indefinitely for its ack.

Test Plan:
- Reset, then I_Valid=1, I_Index=5 for one cycle -> next cycle O_Valid=1, O_OneHot=8'b0010_0000. It holds until I_Ack[5]=1, then O_Valid=0 the following cycle.
- Issue index 2, then I_Ack=8'b0000_0001 (wrong lane) for 3 cycles -> O_OneHot stays 8'b0000_0100. Then I_Ack[2]=1 clears it.
- Back-to-back indices 1,3,6 with no ack -> 1 is issued, 3 is pending, O_Ready=0, and 6 is stalled. Ack lane 1 -> 3 is issued the next cycle and 6 is then accepted into pend.
- Continuous stream 0..7 with I_Ack tied to all-ones -> one issue per cycle, with O_OneHot walking 0x01..0x80 and no bubbles.
- NUM_ENTRY=6, I_Index=7 -> O_Err pulses once, O_Valid stays 0. Reset asserted while in TWO -> O_Valid=0 and O_Ready=1 the next cycle.
- DECODER_TIMEOUT_EN, TIMEOUT=4: issue 4, never ack -> cur is dropped after 4 cycles, O_Timeout pulses, and pend is promoted if present.

Source files
------------

// File: rtl/onehot_issue_decoder.sv
// Binary index to one-hot issue decoder with a valid/ready input handshake, a registered
// one-hot output held until the selected lane acknowledges, and a one-entry pending buffer.
// Optional feature macro: DECODER_TIMEOUT_EN (drop an unacknowledged issue after TIMEOUT cycles).
module onehot_issue_decoder #(
  parameter int unsigned NUM_ENTRY = 8,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned WIDTH_IDX = $clog2(NUM_ENTRY)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Valid,
  input  logic [WIDTH_IDX-1:0] I_Index,
  output logic                 O_Ready,
  output logic                 O_Valid,
  output logic [NUM_ENTRY-1:0] O_OneHot,
  input  logic [NUM_ENTRY-1:0] I_Ack,
  output logic                 O_Err,
  output logic                 O_Timeout
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e               r_state, w_state_nxt;
  logic [NUM_ENTRY-1:0] r_cur_oh, w_cur_oh_nxt;
  logic [WIDTH_IDX-1:0] r_pend_idx, w_pend_idx_nxt;
  logic                 r_err;
  logic                 w_accept, w_idx_ok, w_acc_ok, w_ack, w_tmo, w_drop, w_load_cur;
  logic [NUM_ENTRY-1:0] w_in_oh, w_pend_oh;

  // Pending buffer occupancy alone gates acceptance, so O_Ready is a registered term.
  assign O_Ready  = (r_state != StTwo);
  assign O_Valid  = (r_state != StEmpty);
  assign O_OneHot = r_cur_oh;
  assign O_Err    = r_err;

  assign w_accept = I_Valid & O_Ready;
  assign w_idx_ok = (32'(I_Index) < NUM_ENTRY);
  assign w_acc_ok = w_accept & w_idx_ok;
  // r_cur_oh is zero when nothing is issued, so stray acks fall out here.
  assign w_ack    = |(I_Ack & r_cur_oh);
  assign w_drop   = w_ack | w_tmo;

  // Decode the incoming and the pending index; out-of-range values decode to zero.
  always_comb begin
    w_in_oh   = '0;
    w_pend_oh = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      w_in_oh[i]   = (32'(I_Index) == i);
      w_pend_oh[i] = (32'(r_pend_idx) == i);
    end
  end

  // Next-state: cur/pend FIFO of depth two, with bypass into cur when cur drops.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_oh_nxt   = r_cur_oh;
    w_pend_idx_nxt = r_pend_idx;
    w_load_cur     = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_acc_ok) begin
          w_state_nxt  = StOne;
          w_cur_oh_nxt = w_in_oh;
          w_load_cur   = 1'b1;
        end
      end
      StOne: begin
        if (w_drop) begin
          if (w_acc_ok) begin
            w_cur_oh_nxt = w_in_oh;
            w_load_cur   = 1'b1;
          end else begin
            w_state_nxt  = StEmpty;
            w_cur_oh_nxt = '0;
          end
        end else if (w_acc_ok) begin
          w_state_nxt    = StTwo;
          w_pend_idx_nxt = I_Index;
        end
      end
      StTwo: begin
        if (w_drop) begin
          w_state_nxt  = StOne;
          w_cur_oh_nxt = w_pend_oh;
          w_load_cur   = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = StEmpty;
        w_cur_oh_nxt = '0;
      end
    endcase
  end

  // State, issue and error-pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StEmpty;
      r_cur_oh   <= '0;
      r_pend_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_oh   <= w_cur_oh_nxt;
      r_pend_idx <= w_pend_idx_nxt;
      r_err      <= w_accept & ~w_idx_ok;
    end
  end

`ifdef DECODER_TIMEOUT_EN
  localparam int unsigned WIDTH_CNT = $clog2(TIMEOUT + 1);

  logic [WIDTH_CNT-1:0] r_wait;
  logic                 r_timeout;

  // An ack in the final wait cycle wins over the timeout.
  assign w_tmo     = O_Valid & ~w_ack & (r_wait == WIDTH_CNT'(TIMEOUT - 1));
  assign O_Timeout = r_timeout;

  // Wait counter restarts on every load into cur and counts unacknowledged cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (w_load_cur) begin
        r_wait <= '0;
      end else if (O_Valid && !w_ack) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  // TIMEOUT only matters when the timeout feature is built in.
  assign w_unused_timeout = (TIMEOUT != 0) & w_load_cur;
  assign w_tmo            = 1'b0;
  assign O_Timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_issue_decoder.sv
// Bench for onehot_issue_decoder: a queue-based model checked every cycle, directed vectors with
// literal expectations, and a second NUM_ENTRY=6 instance for the out-of-range index check.
module tb_onehot_issue_decoder;

  localparam int unsigned N  = 8;
  localparam int unsigned TO = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_valid;
  logic [2:0]   i_index;
  logic [N-1:0] i_ack;
  logic         o_ready, o_valid, o_err, o_timeout;
  logic [N-1:0] o_onehot;

  logic         d6_valid;
  logic [2:0]   d6_index;
  logic [5:0]   d6_ack;
  logic         d6_ready, d6_ovalid, d6_err, d6_to;
  logic [5:0]   d6_oh;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  onehot_issue_decoder #(.NUM_ENTRY(N), .TIMEOUT(TO)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .I_Valid   (i_valid),
    .I_Index   (i_index),
    .O_Ready   (o_ready),
    .O_Valid   (o_valid),
    .O_OneHot  (o_onehot),
    .I_Ack     (i_ack),
    .O_Err     (o_err),
    .O_Timeout (o_timeout)
  );

  onehot_issue_decoder #(.NUM_ENTRY(6), .TIMEOUT(TO)) u_dut6 (
    .clock     (clock),
    .reset     (reset),
    .I_Valid   (d6_valid),
    .I_Index   (d6_index),
    .O_Ready   (d6_ready),
    .O_Valid   (d6_ovalid),
    .O_OneHot  (d6_oh),
    .I_Ack     (d6_ack),
    .O_Err     (d6_err),
    .O_Timeout (d6_to)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: issued entries as a queue of indices; head is cur, second is pend.
  int m_q[$];
  bit m_err, m_to, m_en;
  int m_wait;

  task automatic model_step();
    bit valid, ack, tmo, acc, drop, loaded;
    if (reset) begin
      m_q.delete();
      m_err  = 0;
      m_to   = 0;
      m_wait = 0;
      return;
    end
    valid = (m_q.size() > 0);
    ack   = valid && i_ack[m_q[0]];
    tmo   = 0;
`ifdef DECODER_TIMEOUT_EN
    tmo   = valid && !ack && (m_wait == int'(TO) - 1);
`endif
    acc    = i_valid && (m_q.size() < 2);
    m_err  = acc && (int'(i_index) >= int'(N));
    m_to   = tmo;
    drop   = valid && (ack || tmo);
    loaded = drop && (m_q.size() > 1);
    if (drop) void'(m_q.pop_front());
    if (acc && (int'(i_index) < int'(N))) begin
      m_q.push_back(int'(i_index));
      if (m_q.size() == 1) loaded = 1;
    end
    if (loaded) m_wait = 0;
    else if (valid && !drop) m_wait++;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // All DUT outputs are registered, so comparing at the falling edge is race-free.
  initial forever begin
    @(negedge clock);
    if (m_en) begin
      check("valid",   32'(o_valid),   32'(m_q.size() > 0));
      check("ready",   32'(o_ready),   32'(m_q.size() < 2));
      check("onehot",  32'(o_onehot),  (m_q.size() > 0) ? (32'd1 << m_q[0]) : 32'd0);
      check("err",     32'(o_err),     32'(m_err));
      check("timeout", 32'(o_timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] idx, input logic [N-1:0] a);
    i_valid = v;
    i_index = idx;
    i_ack   = a;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, '0);
    d6_valid = 1'b0;
    d6_index = 3'd0;
    d6_ack   = '0;
    tick();
    m_en = 1;
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_oh",    32'(o_onehot), 32'd0);

    // Single issue of index 5, held until lane 5 acks.
    drive(1'b1, 3'd5, '0);
    tick();
    check("t1_oh", 32'(o_onehot), 32'h20);
    drive(1'b0, 3'd0, '0);
    tick();
    tick();
    check("t1_hold", 32'(o_onehot), 32'h20);
    drive(1'b0, 3'd0, 8'h20);
    tick();
    check("t1_clear", 32'(o_valid), 32'd0);

    // Acks on a non-selected lane are ignored.
    drive(1'b1, 3'd2, '0);
    tick();
    drive(1'b0, 3'd0, 8'h01);
    repeat (3) tick();
    check("t2_hold", 32'(o_onehot), 32'h04);
    drive(1'b0, 3'd0, 8'h04);
    tick();
    check("t2_clear", 32'(o_valid), 32'd0);

    // Back-to-back 1,3,6 with no ack: 6 stalls while pend is full.
    drive(1'b1, 3'd1, '0);
    tick();
    drive(1'b1, 3'd3, '0);
    tick();
    check("t3_ready0", 32'(o_ready), 32'd0);
    check("t3_cur1",   32'(o_onehot), 32'h02);
    drive(1'b1, 3'd6, '0);
    tick();
    check("t3_stall", 32'(o_onehot), 32'h02);
    drive(1'b1, 3'd6, 8'h02);
    tick();
    check("t3_cur3",   32'(o_onehot), 32'h08);
    check("t3_ready1", 32'(o_ready), 32'd1);
    drive(1'b1, 3'd6, '0);
    tick();
    check("t3_pend6", 32'(o_ready), 32'd0);
    drive(1'b0, 3'd0, 8'hFF);
    tick();
    check("t3_cur6", 32'(o_onehot), 32'h40);
    tick();
    check("t3_empty", 32'(o_valid), 32'd0);

    // Streaming 0..7 with all lanes acking: one issue per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hFF);
      tick();
      check("t4_walk", 32'(o_onehot), 32'd1 << i);
    end
    drive(1'b0, 3'd0, 8'hFF);
    tick();
    check("t4_drain", 32'(o_valid), 32'd0);
    drive(1'b0, 3'd0, 8'hFF);
    tick();

    // Reset while both entries are occupied.
    drive(1'b1, 3'd4, '0);
    tick();
    drive(1'b1, 3'd7, '0);
    tick();
    check("t5_two", 32'(o_ready), 32'd0);
    drive(1'b0, 3'd0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_valid", 32'(o_valid), 32'd0);
    check("t5_rst_ready", 32'(o_ready), 32'd1);
    tick();

`ifdef DECODER_TIMEOUT_EN
    // Never acked: cur drops after TIMEOUT cycles and pend is promoted.
    drive(1'b1, 3'd4, '0);
    tick();
    drive(1'b1, 3'd3, '0);
    tick();
    drive(1'b0, 3'd0, '0);
    repeat (2 * TO + 4) tick();
`endif

    // NUM_ENTRY=6 instance: indices 6 and 7 are out of range.
    d6_valid = 1'b1;
    d6_index = 3'd7;
    tick();
    check("d6_err7",   32'(d6_err),    32'd1);
    check("d6_valid7", 32'(d6_ovalid), 32'd0);
    check("d6_ready7", 32'(d6_ready),  32'd1);
    d6_valid = 1'b0;
    tick();
    check("d6_err_once", 32'(d6_err), 32'd0);
    d6_valid = 1'b1;
    d6_index = 3'd6;
    tick();
    check("d6_err6", 32'(d6_err), 32'd1);
    d6_index = 3'd5;
    tick();
    check("d6_err5", 32'(d6_err),    32'd0);
    check("d6_oh5",  32'(d6_oh),     32'h20);
    check("d6_v5",   32'(d6_ovalid), 32'd1);
    d6_valid = 1'b0;
    d6_ack   = 6'b10_0000;
    tick();
    check("d6_clear", 32'(d6_ovalid), 32'd0);
    d6_ack = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
